fp_pack_round: RTL
==================

# fp_pack_round

Parametrised, two-stage pipelined floating-point packer for the datapath back end. It takes an unrounded normalised sign/exponent/mantissa result from an arithmetic core and produces the packed IEEE-754 word and exception flags. It performs denormalisation, rounding in four modes, overflow and underflow handling, and special-value encoding. A valid/ready handshake lets it sit between any FP core and the result writeback.

## Interface
Parameters:
- EXP_W, default 11: exponent field width.
- MAN_W, default 52: fraction field width. The packed word is 1+EXP_W+MAN_W bits wide (64 by default).

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block can accept a beat.
- in_sign, in, 1: result sign.
- in_exp, in, EXP_W+2: signed biased exponent of in_man's leading bit. May be ≤0 or ≥2^EXP_W−1.
- in_man, in, MAN_W+4: normalised mantissa.
  - Bit MAN_W+3 is the hidden bit, which must be 1 unless in_man is all zero.
  - Bits 2:0 are guard, round and sticky.
- in_rm, in, 2: rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward −inf).
- in_is_nan, in_is_inf, in_is_zero, in, 1 each: special-value flags.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts the beat.
- out_fp, out, 1+EXP_W+MAN_W: packed result.
- out_flags, out, 3: {overflow, underflow, inexact}.

## Operation
- **Special-value priority:** nan > inf > zero > numeric. All flags are 0 for special values.
  - NaN: {0, all-ones exponent, fraction MSB 1, fraction LSB 1, zeros elsewhere}. For doubles this is 64'h7FF8000000000001.
  - Inf: {in_sign, all-ones exponent, 0}.
  - Zero: {in_sign, 0, 0}. A numeric beat with in_man==0 is also encoded as zero.
- **Stage 1, denormalise:**
  - If in_exp ≤ 0: shift in_man right by 1−in_exp, saturating at MAN_W+4. Every bit shifted out ORs into sticky. Mark the beat tiny.
  - Otherwise no shift.
  - Collapse the result to kept[MAN_W:0], guard G, and sticky S = round|sticky|shifted-out bits.
- **Stage 2, round:**
  - inexact = G|S.
  - Increment rule by mode:
    - RNE: G&(S|kept[0]).
    - RTZ: 0.
    - RUP: (G|S)&~sign.
    - RDN: (G|S)&sign.
  - kept+inc is computed at MAN_W+2 bits.
  - Normal path: a carry out of bit MAN_W means exp+1 and fraction = 0.
  - Tiny path: exponent field = bit MAN_W of the rounded value. A subnormal that rounds up to the hidden bit therefore becomes exponent field 1.
  - underflow = tiny & inexact (tininess is detected before rounding).
- **Overflow:** the final biased exponent is ≥ 2^EXP_W−1. Set overflow and inexact.
  - Result is Inf for RNE, for RUP with positive sign, and for RDN with negative sign.
  - Otherwise the result is the maximum finite value: exponent 2^EXP_W−2, fraction all ones, sign preserved.
- **Arithmetic:** all exponent arithmetic is signed at EXP_W+2 bits. No truncation is allowed before the overflow compare.

## Timing
- **Latency:** 2 cycles from an accepted input beat to out_valid, with full throughput of 1 beat per cycle.
- **Handshake:**
  - An input beat is accepted when in_valid & in_ready.
  - An output beat transfers when out_valid & out_ready.
  - out_valid & ~out_ready holds out_fp and out_flags stable until the transfer.
  - Stage 2 enable: s2_en = out_ready | ~out_valid.
  - Stage 1 enable: s1_en = s2_en | ~s1_valid.
  - in_ready = s1_en, combinational from out_ready.
- **Simultaneous events:** when output drain and input accept happen in the same cycle, both succeed. No bubble is inserted.
- **Reset:** rst_n low at any time, including mid-stream, asynchronously clears s1_valid, out_valid, out_fp and out_flags to 0. In-flight beats are discarded.
- **After reset:** in_ready = 1 in the first cycle after deassertion.

## Structure
- The shared package fp_pkg holds:
  - rounding-mode constants RM_RNE, RM_RTZ, RM_RUP, RM_RDN;
  - flag bit indices;
  - a function returning the quiet-NaN pattern for (EXP_W, MAN_W).
- One sub-module, fp_round_inc: combinational. Takes kept LSB, G, S, sign and rm, and returns inc. It is reused by other rounding blocks.
- The pipeline registers and the special/overflow encode live in the top module.

## Test plan
- **Exact normal:** sign 0, in_exp 1023, in_man hidden 1 with zero fraction and zero G/R/S, RNE -> out_fp 64'h3FF0000000000000, flags 000, 2 cycles after accept.
- **Tie-to-even with carry:** fraction all ones, G=1, R=S=0, exp 1023, RNE -> 64'h4000000000000000, inexact only. The same beat with RTZ -> 64'h3FFFFFFFFFFFFFFF.
- **Overflow:** in_exp 2047, any mantissa.
  - RNE, positive -> 64'h7FF0000000000000, flags 101.
  - RTZ -> 64'h7FEFFFFFFFFFFFFF.
  - RDN with positive sign -> 64'h7FEFFFFFFFFFFFFF.
- **Underflow/subnormal:** in_exp 0, hidden 1, G=1, RNE -> exponent field 0, fraction 2^51, flags 011. in_exp −60, RUP, positive -> 64'h0000000000000001, flags 011.
- **Specials:**
  - in_is_nan together with in_is_inf -> 64'h7FF8000000000001.
  - in_is_zero with sign 1 -> 64'h8000000000000000.
  - Flags 000 in both cases.
- **Backpressure and reset:**
  - Stream 4 beats with out_ready low for 3 cycles -> in_ready drops, and out_fp is held stable until out_ready returns.
  - No beat is lost or duplicated, and beats leave in order.
  - rst_n pulsed low mid-stream -> out_valid drops immediately, and the pipeline is empty afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point constants: rounding modes, flag bit positions and
// the quiet-NaN pattern used by the packers.
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam int FLAG_INX = 0;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_OVF = 2;

    localparam int QNAN_MAX_W = 128;

    // Positive quiet NaN with both the fraction MSB and LSB set; callers keep the low 1+exp_w+man_w bits.
    function automatic logic [QNAN_MAX_W-1:0] qnan_pattern(input int exp_w, input int man_w);
        logic [QNAN_MAX_W-1:0] r_pat;
        r_pat = (((QNAN_MAX_W)'(1) << exp_w) - (QNAN_MAX_W)'(1)) << man_w;
        r_pat = r_pat | ((QNAN_MAX_W)'(1) << (man_w - 1)) | (QNAN_MAX_W)'(1);
        return r_pat;
    endfunction

endpackage

// File: rtl/fp_pack_round_if.sv
// Valid/ready bus between an FP arithmetic core, the packer and the writeback.
interface fp_pack_round_if #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_sign;
    logic signed [EXP_W+1:0]   in_exp;
    logic [MAN_W+3:0]          in_man;
    logic [1:0]                in_rm;
    logic                      in_is_nan;
    logic                      in_is_inf;
    logic                      in_is_zero;
    logic                      out_valid;
    logic                      out_ready;
    logic [EXP_W+MAN_W:0]      out_fp;
    logic [2:0]                out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_man, in_rm, in_is_nan, in_is_inf, in_is_zero,
        output out_ready,
        input  in_ready, out_valid, out_fp, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_man, in_rm, in_is_nan, in_is_inf, in_is_zero,
        input  out_ready,
        output in_ready, out_valid, out_fp, out_flags
    );
endinterface

// File: rtl/fp_round_inc.sv
// Rounding-increment decision from kept LSB, guard, sticky, sign and mode.
module fp_round_inc
    import fp_pkg::*;
(
    input  logic       i_lsb,
    input  logic       i_g,
    input  logic       i_s,
    input  logic       i_sign,
    input  logic [1:0] i_rm,
    output logic       o_inc
);

    always_comb begin
        o_inc = 1'b0;
        case (i_rm)
            RM_RNE:  o_inc = i_g & (i_s | i_lsb);
            RM_RUP:  o_inc = (i_g | i_s) & ~i_sign;
            RM_RDN:  o_inc = (i_g | i_s) & i_sign;
            default: o_inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_pack_round.sv
// Two-stage packer: stage 1 denormalises into kept/guard/sticky, stage 2
// rounds and encodes overflow, subnormal and special values.
module fp_pack_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_pack_round_if.slave bus
);

    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int MW   = MAN_W + 4;
    localparam int SA_W = $clog2(MW + 1);
    localparam logic [FP_W-1:0]    QNAN    = FP_W'(qnan_pattern(EXP_W, MAN_W));
    localparam logic signed [EW:0] EXP_MAX = (EW+1)'((1 << EXP_W) - 1);

    function automatic logic [FP_W-1:0] ovf_result(input logic sign, input logic [1:0] rm);
        logic to_inf;
        to_inf = (rm == RM_RNE) || (rm == RM_RUP && !sign) || (rm == RM_RDN && sign);
        if (to_inf)
            return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        return {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    endfunction

    logic w_s1_en, w_s2_en;
    logic r_vld_p1, r_vld_p2;

    assign w_s2_en      = bus.out_ready | ~r_vld_p2;
    assign w_s1_en      = w_s2_en | ~r_vld_p1;
    assign bus.in_ready = w_s1_en;

    // ---- stage 1: denormalise ----
    logic signed [EW:0] w_shamt_full;
    logic               w_tiny_p0;
    logic [SA_W-1:0]    w_sh;
    logic [2*MW-1:0]    w_wide;

    assign w_shamt_full = (EW+1)'(1) - (EW+1)'(bus.in_exp);
    assign w_tiny_p0    = bus.in_exp[EW-1] || (bus.in_exp == '0);

    always_comb begin
        w_sh = '0;
        if (w_tiny_p0) begin
            if (w_shamt_full > (EW+1)'(MW))
                w_sh = SA_W'(MW);
            else
                w_sh = SA_W'(w_shamt_full);
        end
    end

    // Lower half catches every bit shifted out, so sticky is one reduction-OR.
    assign w_wide = {bus.in_man, {MW{1'b0}}} >> w_sh;

    logic                   r_sign_p1, r_g_p1, r_s_p1, r_tiny_p1;
    logic                   r_nan_p1, r_inf_p1, r_zero_p1;
    logic signed [EW-1:0]   r_exp_p1;
    logic [MAN_W:0]         r_kept_p1;
    logic [1:0]             r_rm_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_vld_p1 <= 1'b0;
        else if (w_s1_en)
            r_vld_p1 <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (w_s1_en && bus.in_valid) begin
            r_sign_p1 <= bus.in_sign;
            r_exp_p1  <= bus.in_exp;
            r_kept_p1 <= w_wide[2*MW-1:MW+3];
            r_g_p1    <= w_wide[MW+2];
            r_s_p1    <= w_wide[MW+1] | w_wide[MW] | (|w_wide[MW-1:0]);
            r_tiny_p1 <= w_tiny_p0;
            r_rm_p1   <= bus.in_rm;
            r_nan_p1  <= bus.in_is_nan;
            r_inf_p1  <= bus.in_is_inf;
            r_zero_p1 <= bus.in_is_zero | (bus.in_man == '0);
        end
    end

    // ---- stage 2: round and encode ----
    logic               w_inc, w_inexact, w_ovf;
    logic [MAN_W+1:0]   w_rounded;
    logic signed [EW:0] w_carry_ext, w_exp_fin;
    logic [FP_W-1:0]    w_fp;
    logic [2:0]         w_flags;

    fp_round_inc u_round_inc (
        .i_lsb  (r_kept_p1[0]),
        .i_g    (r_g_p1),
        .i_s    (r_s_p1),
        .i_sign (r_sign_p1),
        .i_rm   (r_rm_p1),
        .o_inc  (w_inc)
    );

    assign w_rounded   = {1'b0, r_kept_p1} + (MAN_W+2)'(w_inc);
    assign w_inexact   = r_g_p1 | r_s_p1;
    assign w_carry_ext = {{EW{1'b0}}, w_rounded[MAN_W+1]};

    // A subnormal's exponent field is simply whether rounding reached the hidden bit.
    always_comb begin
        if (r_tiny_p1)
            w_exp_fin = {{EW{1'b0}}, w_rounded[MAN_W]};
        else
            w_exp_fin = (EW+1)'(r_exp_p1) + w_carry_ext;
    end

    assign w_ovf = !r_tiny_p1 && (w_exp_fin >= EXP_MAX);

    always_comb begin
        w_fp    = '0;
        w_flags = '0;
        if (r_nan_p1) begin
            w_fp = QNAN;
        end else if (r_inf_p1) begin
            w_fp = {r_sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (r_zero_p1) begin
            w_fp = {r_sign_p1, {(EXP_W+MAN_W){1'b0}}};
        end else if (w_ovf) begin
            w_fp              = ovf_result(r_sign_p1, r_rm_p1);
            w_flags[FLAG_OVF] = 1'b1;
            w_flags[FLAG_INX] = 1'b1;
        end else begin
            w_fp              = {r_sign_p1, w_exp_fin[EXP_W-1:0], w_rounded[MAN_W-1:0]};
            w_flags[FLAG_UNF] = r_tiny_p1 & w_inexact;
            w_flags[FLAG_INX] = w_inexact;
        end
    end

    logic [FP_W-1:0] r_fp_p2;
    logic [2:0]      r_flags_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2   <= 1'b0;
            r_fp_p2    <= '0;
            r_flags_p2 <= '0;
        end else if (w_s2_en) begin
            r_vld_p2   <= r_vld_p1;
            r_fp_p2    <= w_fp;
            r_flags_p2 <= w_flags;
        end
    end

    assign bus.out_valid = r_vld_p2;
    assign bus.out_fp    = r_fp_p2;
    assign bus.out_flags = r_flags_p2;

endmodule
